spi_master_tx: RTL and testbench
================================

# spi_master_tx

SPI mode-0 master serializer sitting directly downstream of `data_former`. It accepts one `P_DATA_WIDTH`-bit word per valid/ready handshake and shifts it MSB-first onto `mosi`, framed by `cs_n`, with `sclk` derived from `clk_100`. An optional receive path captures `miso` for full-duplex transfers.

## Interface
- `P_DATA_WIDTH`, 8: word width in bits, ≥2.
- `P_CLK_DIV`, 4: `sclk` half-period in `clk_100` cycles, ≥1.
- `clk_100`  in  1  system clock, all logic on rising edge.
- `s_rst`  in  1  reset; synchronous and active-high.
- `valid`  in  1  word available from `data_former`.
- `data`  in  `P_DATA_WIDTH`  word to send; sampled only on handshake.
- `ready`  out  1  block can accept a word.
- `sclk`  out  1  SPI clock, idles low (CPOL=0).
- `mosi`  out  1  serial data out, MSB first.
- `cs_n`  out  1  chip select, active low.
- `busy`  out  1  high while `cs_n` is low.
- `done`  out  1  one-cycle pulse at transfer completion.
- `miso`  in  1  serial data in (used only with `SPI_MASTER_RX_EN`).
- `rx_data`  out  `P_DATA_WIDTH`  received word (`SPI_MASTER_RX_EN` only).
- `rx_valid`  out  1  one-cycle pulse with `rx_data` (`SPI_MASTER_RX_EN` only).

## Operation
- Reset values: `ready`=1, `sclk`=0, `mosi`=0, `cs_n`=1, `busy`=0, `done`=0, `rx_data`=0, `rx_valid`=0, state IDLE, counters 0.
- `ready` = (state == IDLE), decoded from the state register.
- A handshake is `valid && ready` on a rising edge. `data` is latched into the shift register. `valid` without `ready` is ignored; the source holds the word.
- FSM:
  - IDLE: on handshake, go to SETUP; `cs_n`←0; `mosi`←`data[MSB]`; divider cleared.
  - SETUP: wait one half-period (`P_CLK_DIV` cycles), then `sclk`←1 and go to SHIFT.
  - SHIFT: on each divider tick, `sclk` toggles.
    - Rising `sclk` edge: sample `miso` into the receive shift register.
    - Falling `sclk` edge: shift the next bit onto `mosi`.
    - After the `P_DATA_WIDTH`-th falling edge, go to HOLD with `sclk`=0. `mosi` holds the last bit.
  - HOLD: wait one half-period, then go to IDLE. At the same edge: `cs_n`←1, `mosi`←0, `done`←1 for one cycle, and `rx_valid`←1 for one cycle.
- Divider: counts 0..`P_CLK_DIV`-1 and emits a tick on terminal count; it runs only outside IDLE. Width is max(1, $clog2(`P_CLK_DIV`)).
- Bit counter: width $clog2(`P_DATA_WIDTH`+1). It counts falling edges and does not wrap within a frame.
- Reset mid-transfer: at the next edge all outputs return to reset values. The frame is aborted with no `done` and no `rx_valid`.

## Timing
- Handshake at edge N: `cs_n`=0 and `mosi`=MSB visible after edge N.
- First `sclk` rise comes `P_CLK_DIV` cycles after `cs_n` falls.
- `cs_n` stays low for (2·`P_DATA_WIDTH`+2)·`P_CLK_DIV` cycles. Default: 72 cycles.
- `ready` returns in the same cycle that `cs_n` rises and `done` pulses. A back-to-back handshake at that edge gives a minimum `cs_n`-high gap of exactly 1 cycle.
- `P_CLK_DIV`=1 gives `sclk` = `clk_100`/2, i.e. 50 MHz.

## Configuration
- `SPI_MASTER_RX_EN` defined: `miso` is sampled on rising `sclk` edges, MSB first. `rx_data` updates at the HOLD→IDLE edge together with the `rx_valid` pulse, and holds its value until the next completed frame.
- Not defined: the receive shift register, `rx_data` and `rx_valid` are not generated; the `miso`, `rx_data` and `rx_valid` ports are absent. Transmit behaviour is identical in both cases.

## Structure
- Package `spi_pkg`: `spi_state_t` enum {IDLE, SETUP, SHIFT, HOLD}; constants `SPI_CPOL=0` and `SPI_CPHA=0`.
- Sub-module `spi_clk_div`: parameter `P_CLK_DIV`; ports `clk_100`, `s_rst`, `en`, `tick`. It produces the half-period tick.

## Test plan
- Reset: assert `s_rst` for 2 cycles → `ready`=1, `cs_n`=1, `sclk`=0, `mosi`=0, `done`=0.
- Single word 0xA5, `P_CLK_DIV`=4 → `mosi` is 1,0,1,0,0,1,0,1 at the 8 rising `sclk` edges; `cs_n` low for 72 cycles; one `done` pulse.
- Back-to-back: `valid` held high with 0x3C then 0xFF → both frames sent; `cs_n` high for exactly 1 cycle between them; 2 `done` pulses.
- `valid` asserted while busy with data changing → the word in flight is unaffected; the new word is taken only when `ready`=1.
- Reset mid-frame, asserted after the 3rd `sclk` rise → `cs_n`=1 and `sclk`=0 next cycle; no `done`; the next word transmits cleanly.
- `SPI_MASTER_RX_EN`: `miso` loopback from `mosi` with word 0x5A → `rx_data`=0x5A and `rx_valid` pulses in the same cycle as `done`.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI mode-0 master
//                serializer (state encoding, clock polarity/phase).
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Transfer phases of one framed SPI word
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    // Mode 0: sclk idles low, data sampled on the rising sclk edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : spi_clk_div
//  Description : Half-period tick generator for the SPI master. Counts
//                0..P_CLK_DIV-1 while enabled and pulses tick on the
//                terminal count; held at zero while disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
    parameter int P_CLK_DIV = 4
) (
    input  logic clk_100,
    input  logic s_rst,
    input  logic en,
    output logic tick
);

    localparam int                 c_CNT_W = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TC    = c_CNT_W'(P_CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Free-running half-period counter, cleared whenever the master is idle
    always_ff @(posedge clk_100) begin
        if (s_rst || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == c_TC) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign tick = en && (r_cnt == c_TC);

endmodule : spi_clk_div
`default_nettype wire

// File: rtl/spi_master_tx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_tx
//  Description : SPI mode-0 master serializer. Accepts one word per
//                valid/ready handshake and shifts it MSB-first onto mosi,
//                framed by cs_n. Optional full-duplex receive path enabled
//                by the SPI_MASTER_RX_EN macro (adds miso/rx_data/rx_valid).
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_CLK_DIV    = 4
) (
    input  logic                    clk_100,
    input  logic                    s_rst,
    input  logic                    valid,
    input  logic [P_DATA_WIDTH-1:0] data,
    output logic                    ready,
    output logic                    sclk,
    output logic                    mosi,
    output logic                    cs_n,
    output logic                    busy,
    output logic                    done
`ifdef SPI_MASTER_RX_EN
    ,
    input  logic                    miso,
    output logic [P_DATA_WIDTH-1:0] rx_data,
    output logic                    rx_valid
`endif
);

    localparam int                 c_BIT_W    = $clog2(P_DATA_WIDTH + 1);
    localparam logic [c_BIT_W-1:0] c_BIT_FULL = c_BIT_W'(P_DATA_WIDTH);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(P_DATA_WIDTH - 1);

    spi_state_t                r_state,   w_state_nxt;
    logic [P_DATA_WIDTH-1:0]   r_shift,   w_shift_nxt;
    logic [c_BIT_W-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic                      r_sclk,    w_sclk_nxt;
    logic                      r_mosi,    w_mosi_nxt;
    logic                      r_cs_n,    w_cs_n_nxt;
    logic                      r_done;
    logic                      w_frame_end;
    logic                      w_tick;
    logic                      w_div_en;

    assign w_div_en = (r_state != IDLE);

    spi_clk_div #(
        .P_CLK_DIV (P_CLK_DIV)
    ) u_clk_div (
        .clk_100 (clk_100),
        .s_rst   (s_rst),
        .en      (w_div_en),
        .tick    (w_tick)
    );

    // Register every piece of frame state; reset aborts any frame in flight
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= SPI_CPOL;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_done    <= w_frame_end;
        end
    end

    // Next-state and next-output decode. r_shift holds the bits still to be
    // sent, left-aligned, so the next mosi bit is always its MSB. After the
    // last falling edge the FSM idles one more half-period in SHIFT with
    // sclk low before the HOLD half-period, giving the full frame length.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_cs_n_nxt    = r_cs_n;
        w_frame_end   = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid) begin
                    w_state_nxt   = SETUP;
                    w_cs_n_nxt    = 1'b0;
                    w_mosi_nxt    = data[P_DATA_WIDTH-1];
                    w_shift_nxt   = {data[P_DATA_WIDTH-2:0], 1'b0};
                    w_bit_cnt_nxt = '0;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_BIT_FULL) begin
                        w_state_nxt = HOLD;
                    end else if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        w_sclk_nxt    = 1'b0;
                        w_bit_cnt_nxt = r_bit_cnt + c_BIT_W'(1);
                        if (r_bit_cnt != c_BIT_LAST) begin
                            w_mosi_nxt  = r_shift[P_DATA_WIDTH-1];
                            w_shift_nxt = {r_shift[P_DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_cs_n_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ready = (r_state == IDLE);
    assign sclk  = r_sclk;
    assign mosi  = r_mosi;
    assign cs_n  = r_cs_n;
    assign busy  = ~r_cs_n;
    assign done  = r_done;

`ifdef SPI_MASTER_RX_EN
    logic [P_DATA_WIDTH-1:0] r_rx_shift;
    logic [P_DATA_WIDTH-1:0] r_rx_data;
    logic                    r_rx_valid;
    logic                    w_sample;

    // A rising sclk edge is produced by the SETUP tick or a low-phase SHIFT tick
    assign w_sample = w_tick && ((r_state == SETUP) ||
                      ((r_state == SHIFT) && !r_sclk && (r_bit_cnt != c_BIT_FULL)));

    // Capture miso MSB-first; publish the word together with done
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[P_DATA_WIDTH-2:0], miso};
            end
            if (w_frame_end) begin
                r_rx_data <= r_rx_shift;
            end
            r_rx_valid <= w_frame_end;
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
`endif

endmodule : spi_master_tx
`default_nettype wire

// File: tb/tb_spi_master_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_tx
//  Description : Self-checking bench for spi_master_tx. A cycle-offset
//                reference model predicts every output from the frame
//                timing rules; a frame monitor reassembles mosi at sclk
//                rises. With SPI_MASTER_RX_EN, miso is looped from mosi.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_tx;

    localparam int W = 8;
    localparam int P = 4;
    localparam int L = (2 * W + 2) * P;   // cs_n low time in cycles

    logic         clk_100 = 1'b0;
    logic         s_rst   = 1'b1;
    logic         valid   = 1'b0;
    logic [W-1:0] data    = '0;
    logic         ready, sclk, mosi, cs_n, busy, done;
`ifdef SPI_MASTER_RX_EN
    logic         miso;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    assign miso = mosi;
`endif

    always #5 clk_100 = ~clk_100;

    spi_master_tx #(
        .P_DATA_WIDTH (W),
        .P_CLK_DIV    (P)
    ) dut (
        .clk_100  (clk_100),
        .s_rst    (s_rst),
        .valid    (valid),
        .data     (data),
        .ready    (ready),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .busy     (busy),
        .done     (done)
`ifdef SPI_MASTER_RX_EN
        ,
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: offset k counts cycles since the accepting edge
    bit           m_active  = 1'b0;
    int           m_k       = 0;
    logic [W-1:0] m_word    = '0;
    bit           m_done    = 1'b0;
    logic [W-1:0] m_rx_data = '0;

    // Frame monitor state
    logic         prev_sclk = 1'b0;
    logic         prev_cs_n = 1'b1;
    logic [W-1:0] obs_bits  = '0;
    int           obs_nbits = 0;
    int           obs_low   = 0;
    int           obs_gap   = 0;
    int           last_gap  = 0;
    int           done_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d, input logic r);
        if (r) begin
            m_active  = 1'b0;
            m_done    = 1'b0;
            m_k       = 0;
            m_rx_data = '0;
        end else if (!m_active) begin
            m_done = 1'b0;
            if (v) begin
                m_active = 1'b1;
                m_k      = 0;
                m_word   = d;
            end
        end else if (m_k == L - 1) begin
            m_active  = 1'b0;
            m_done    = 1'b1;
            m_rx_data = m_word;
        end else begin
            m_k++;
        end
    endtask

    task automatic compare_all();
        int   q;
        int   b;
        logic e_sclk;
        logic e_mosi;
        q = m_k / P;
        b = m_k / (2 * P);
        if (b > W - 1) b = W - 1;
        e_sclk = m_active && (q % 2 == 1) && (q <= 2 * W - 1);
        e_mosi = m_active ? m_word[W-1-b] : 1'b0;
        check("ready", 32'(ready), 32'(!m_active));
        check("cs_n",  32'(cs_n),  32'(!m_active));
        check("busy",  32'(busy),  32'(m_active));
        check("sclk",  32'(sclk),  32'(e_sclk));
        check("mosi",  32'(mosi),  32'(e_mosi));
        check("done",  32'(done),  32'(m_done));
`ifdef SPI_MASTER_RX_EN
        check("rx_valid", 32'(rx_valid), 32'(m_done));
        check("rx_data",  32'(rx_data),  32'(m_rx_data));
`endif
        // Frame-level monitor built purely from observed pins
        if (cs_n === 1'b0) begin
            if (prev_cs_n === 1'b1) begin
                obs_bits  = '0;
                obs_nbits = 0;
                obs_low   = 0;
                last_gap  = obs_gap;
            end
            obs_low++;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                obs_bits = {obs_bits[W-2:0], mosi};
                obs_nbits++;
            end
            obs_gap = 0;
        end else begin
            obs_gap++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("frame_word", 32'(obs_bits), 32'(m_word));
            check("frame_bits", 32'(obs_nbits), 32'(W));
            check("cs_low_len", 32'(obs_low), 32'(L));
        end
        if (s_rst) begin
            obs_nbits = 0;
            obs_bits  = '0;
        end
        prev_sclk = sclk;
        prev_cs_n = cs_n;
    endtask

    // Apply inputs for the next rising edge, advance the model, then compare
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        valid = v;
        data  = d;
        s_rst = r;
        model_step(v, d, r);
        @(negedge clk_100);
        compare_all();
    endtask

    initial begin
        int           d0;
        logic [W-1:0] rd;
        logic         rv;
        logic         rr;

        // Reset for two cycles
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Single word 0xA5
        d0 = done_cnt;
        step(1'b1, 8'hA5, 1'b0);
        repeat (L + 2) step(1'b0, 8'h00, 1'b0);
        check("a5_done_count", 32'(done_cnt - d0), 32'd1);

        // Back-to-back with valid held: 0x3C then 0xFF
        d0 = done_cnt;
        step(1'b1, 8'h3C, 1'b0);
        repeat (L + 1) step(1'b1, 8'hFF, 1'b0);
        repeat (L + 2) step(1'b0, 8'h00, 1'b0);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        check("b2b_cs_gap", 32'(last_gap), 32'd1);

        // Valid held with data changing while busy
        step(1'b1, 8'h81, 1'b0);
        repeat (L + 1) begin
            rd = 8'($urandom);
            step(1'b1, rd, 1'b0);
        end
        repeat (L + 2) step(1'b0, 8'h00, 1'b0);

        // Reset after the third sclk rise
        step(1'b1, 8'hC3, 1'b0);
        repeat (5 * P) step(1'b0, 8'h00, 1'b0);
        d0 = done_cnt;
        step(1'b0, 8'h00, 1'b1);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        repeat (L + 2) step(1'b0, 8'h00, 1'b0);
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        d0 = done_cnt;
        step(1'b1, 8'h96, 1'b0);
        repeat (L + 2) step(1'b0, 8'h00, 1'b0);
        check("post_rst_done", 32'(done_cnt - d0), 32'd1);

        // Loopback word 0x5A
        step(1'b1, 8'h5A, 1'b0);
        repeat (L + 2) step(1'b0, 8'h00, 1'b0);

        // Randomized traffic with occasional resets
        repeat (3000) begin
            rd = 8'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 499) == 0);
            step(rv, rd, rr);
        end
        repeat (L + 2) step(1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_spi_master_tx
`default_nettype wire
